// File: rtl/ccd_pixel_packer_if.sv
// Signal bundle between the frame controller / AD9826 capture side, the packer
// and the tx_fifo write port. The packer connects through the slave modport.
interface ccd_pixel_packer_if;
   logic        start;
   logic [11:0] n_cols;
   logic [11:0] n_rows;
   logic [7:0]  ad_data;
   logic        ad_hi_valid;
   logic        ad_lo_valid;
   logic [7:0]  tx_fifo_wdata;
   logic        tx_fifo_winc;
   logic        tx_fifo_wfull;
   logic        busy;
   logic        frame_done;
   logic        overflow;

   modport master (
      output start, n_cols, n_rows, ad_data, ad_hi_valid, ad_lo_valid, tx_fifo_wfull,
      input  tx_fifo_wdata, tx_fifo_winc, busy, frame_done, overflow
   );

   modport slave (
      input  start, n_cols, n_rows, ad_data, ad_hi_valid, ad_lo_valid, tx_fifo_wfull,
      output tx_fifo_wdata, tx_fifo_winc, busy, frame_done, overflow
   );
endinterface

// File: rtl/ccd_pixel_packer.sv
// Packs AD9826 hi/lo byte pairs into a framed byte stream for tx_fifo:
// A5 5A, pixel bytes (high first), 5A A5, dropped-pixel count.
module ccd_pixel_packer #(
   parameter int unsigned DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   ccd_pixel_packer_if.slave  bus
);

   localparam int unsigned    AW       = $clog2(DEPTH);
   localparam logic [AW:0]    FULL_CNT = (AW + 1)'(DEPTH);
   localparam logic [AW:0]    PTR_ONE  = (AW + 1)'(1);
   localparam logic [AW:0]    PTR_ZERO = (AW + 1)'(0);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      HDR0 = 3'd1,
      HDR1 = 3'd2,
      PIX  = 3'd3,
      TRL0 = 3'd4,
      TRL1 = 3'd5,
      TRL2 = 3'd6,
      DONE = 3'd7
   } state_t;

   state_t       state_q;
   logic [23:0]  total_q;
   logic [23:0]  rx_cnt_q;
   logic [7:0]   drop_cnt_q;
   logic [7:0]   drop_cnt_d;
   logic [7:0]   hi_q;
   logic         hi_seen_q;
   logic         lo_phase_q;
   logic [AW:0]  wr_ptr_q;
   logic [AW:0]  rd_ptr_q;
   logic [15:0]  mem_q [DEPTH];
   logic [7:0]   wdata_q;
   logic         winc_q;
   logic         busy_q;
   logic         frame_done_q;
   logic         overflow_q;

   logic [AW:0]  count_s;
   logic         empty_s;
   logic         full_s;
   logic [15:0]  head_s;
   logic         wr_ok_s;
   logic         cap_en_s;
   logic         hi_load_s;
   logic         pix_done_s;
   logic         pop_s;
   logic         push_s;
   logic         drop_s;

   // Buffer status, write permission, pixel capture and push/pop/drop decisions.
   always_comb begin
      count_s  = wr_ptr_q - rd_ptr_q;
      empty_s  = (count_s == PTR_ZERO);
      full_s   = (count_s == FULL_CNT);
      head_s   = mem_q[rd_ptr_q[AW-1:0]];
      // winc_q high means a byte went out this cycle, so the next slot is a gap.
      wr_ok_s  = ~winc_q & ~bus.tx_fifo_wfull;
      cap_en_s = (state_q == PIX) && (rx_cnt_q < total_q);
      if (cap_en_s && !(bus.ad_hi_valid && bus.ad_lo_valid)) begin
         hi_load_s  = bus.ad_hi_valid;
         pix_done_s = bus.ad_lo_valid & hi_seen_q;
      end else begin
         hi_load_s  = 1'b0;
         pix_done_s = 1'b0;
      end
      pop_s  = (state_q == PIX) & wr_ok_s & ~empty_s & lo_phase_q;
      push_s = pix_done_s & (~full_s | pop_s);
      drop_s = pix_done_s & full_s & ~pop_s;
      if (drop_s && (drop_cnt_q != 8'hFF)) begin
         drop_cnt_d = drop_cnt_q + 8'd1;
      end else begin
         drop_cnt_d = drop_cnt_q;
      end
   end

   // Pixel skid-buffer storage; contents are qualified by the pointers.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_q[wr_ptr_q[AW-1:0]] <= {hi_q, bus.ad_data};
      end
   end

   // Frame FSM with registered tx_fifo write port, status outputs and counters.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         total_q      <= 24'd0;
         rx_cnt_q     <= 24'd0;
         drop_cnt_q   <= 8'd0;
         hi_q         <= 8'd0;
         hi_seen_q    <= 1'b0;
         lo_phase_q   <= 1'b0;
         wr_ptr_q     <= PTR_ZERO;
         rd_ptr_q     <= PTR_ZERO;
         wdata_q      <= 8'h00;
         winc_q       <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         winc_q     <= 1'b0;
         drop_cnt_q <= drop_cnt_d;
         if (hi_load_s) begin
            hi_q      <= bus.ad_data;
            hi_seen_q <= 1'b1;
         end else if (pix_done_s) begin
            hi_seen_q <= 1'b0;
         end
         if (pix_done_s) begin
            rx_cnt_q <= rx_cnt_q + 24'd1;
         end
         if (push_s) begin
            wr_ptr_q <= wr_ptr_q + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_q <= rd_ptr_q + PTR_ONE;
         end
         if (drop_s) begin
            overflow_q <= 1'b1;
         end

         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  total_q    <= 24'(bus.n_cols) * 24'(bus.n_rows);
                  rx_cnt_q   <= 24'd0;
                  drop_cnt_q <= 8'd0;
                  overflow_q <= 1'b0;
                  hi_seen_q  <= 1'b0;
                  lo_phase_q <= 1'b0;
                  wr_ptr_q   <= PTR_ZERO;
                  rd_ptr_q   <= PTR_ZERO;
                  busy_q     <= 1'b1;
                  state_q    <= HDR0;
               end
            end
            HDR0: begin
               if (wr_ok_s) begin
                  winc_q  <= 1'b1;
                  wdata_q <= 8'hA5;
                  state_q <= HDR1;
               end
            end
            HDR1: begin
               if (wr_ok_s) begin
                  winc_q  <= 1'b1;
                  wdata_q <= 8'h5A;
                  state_q <= (total_q == 24'd0) ? TRL0 : PIX;
               end
            end
            PIX: begin
               if (wr_ok_s && !empty_s) begin
                  winc_q <= 1'b1;
                  if (!lo_phase_q) begin
                     wdata_q    <= head_s[15:8];
                     lo_phase_q <= 1'b1;
                  end else begin
                     wdata_q    <= head_s[7:0];
                     lo_phase_q <= 1'b0;
                  end
               end else if ((rx_cnt_q == total_q) && empty_s && !lo_phase_q) begin
                  state_q <= TRL0;
               end
            end
            TRL0: begin
               if (wr_ok_s) begin
                  winc_q  <= 1'b1;
                  wdata_q <= 8'h5A;
                  state_q <= TRL1;
               end
            end
            TRL1: begin
               if (wr_ok_s) begin
                  winc_q  <= 1'b1;
                  wdata_q <= 8'hA5;
                  state_q <= TRL2;
               end
            end
            TRL2: begin
               if (wr_ok_s) begin
                  winc_q  <= 1'b1;
                  wdata_q <= drop_cnt_q;
                  state_q <= DONE;
               end
            end
            DONE: begin
               // First DONE cycle carries the last winc; the pulse follows it.
               if (!frame_done_q) begin
                  frame_done_q <= 1'b1;
               end else begin
                  frame_done_q <= 1'b0;
                  busy_q       <= 1'b0;
                  state_q      <= IDLE;
               end
            end
            default: begin
               state_q      <= IDLE;
               busy_q       <= 1'b0;
               frame_done_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.tx_fifo_wdata = wdata_q;
   assign bus.tx_fifo_winc  = winc_q;
   assign bus.busy          = busy_q;
   assign bus.frame_done    = frame_done_q;
   assign bus.overflow      = overflow_q;

endmodule

// File: tb/tb_ccd_pixel_packer.sv
// Directed + randomized bench for ccd_pixel_packer; expected byte streams are
// built from the frame format and the list of pixels that should survive.
module tb_ccd_pixel_packer;

   localparam int DEPTH = 4;

   logic clk;
   logic rst_n;
   ccd_pixel_packer_if ifc ();

   ccd_pixel_packer #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc)
   );

   int          checks    = 0;
   int          failures  = 0;
   logic [7:0]  got[$];
   logic [7:0]  exp_q[$];
   logic [15:0] pix_q[$];
   bit          rand_wfull = 1'b0;
   int          full_run   = 0;
   int          viol_full  = 0;
   int          viol_b2b   = 0;
   logic        winc_last  = 1'b0;
   logic        wfull_last = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Byte capture and write-port protocol observation, away from the active edge.
   always @(negedge clk) begin
      if (ifc.tx_fifo_winc) begin
         got.push_back(ifc.tx_fifo_wdata);
         if (wfull_last) viol_full <= viol_full + 1;
         if (winc_last) viol_b2b <= viol_b2b + 1;
      end
      winc_last  <= ifc.tx_fifo_winc;
      wfull_last <= ifc.tx_fifo_wfull;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_wfull) begin
         if (full_run >= 3) ifc.tx_fifo_wfull = 1'b0;
         else ifc.tx_fifo_wfull = 1'($urandom_range(0, 1));
         full_run = ifc.tx_fifo_wfull ? full_run + 1 : 0;
      end
   endtask

   task automatic build_exp(input int keep, input logic [7:0] drops);
      exp_q.delete();
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h5A);
      for (int i = 0; i < keep; i++) begin
         exp_q.push_back(pix_q[i][15:8]);
         exp_q.push_back(pix_q[i][7:0]);
      end
      exp_q.push_back(8'h5A);
      exp_q.push_back(8'hA5);
      exp_q.push_back(drops);
   endtask

   task automatic check_frame(input string tag);
      int n;
      check({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
      n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s_b%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
      end
   endtask

   task automatic start_frame(input string tag, input logic [11:0] cols, input logic [11:0] rows);
      got.delete();
      ifc.n_cols = cols;
      ifc.n_rows = rows;
      ifc.start  = 1'b1;
      tick();
      ifc.start  = 1'b0;
      ifc.n_cols = 12'($urandom);
      ifc.n_rows = 12'($urandom);
      check({tag, "_busy_start"}, 32'(ifc.busy), 32'd1);
      check({tag, "_ovf_start"}, 32'(ifc.overflow), 32'd0);
   endtask

   task automatic wait_bytes(input string tag, input int n);
      for (int i = 0; i < 400; i++) begin
         if (got.size() >= n) break;
         tick();
      end
      check({tag, "_hdr_seen"}, 32'(got.size() >= n), 32'd1);
   endtask

   task automatic send_px(input logic [15:0] px, input int gap);
      ifc.ad_data     = px[15:8];
      ifc.ad_hi_valid = 1'b1;
      tick();
      ifc.ad_hi_valid = 1'b0;
      ifc.ad_data     = 8'($urandom);
      repeat (gap) tick();
      ifc.ad_data     = px[7:0];
      ifc.ad_lo_valid = 1'b1;
      tick();
      ifc.ad_lo_valid = 1'b0;
      ifc.ad_data     = 8'($urandom);
   endtask

   task automatic wait_done(input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < 20000; i++) begin
         tick();
         if (ifc.frame_done) begin
            seen = 1'b1;
            break;
         end
      end
      check({tag, "_done"}, 32'(seen), 32'd1);
      check({tag, "_busy_at_done"}, 32'(ifc.busy), 32'(seen));
      tick();
      check({tag, "_done_pulse"}, 32'(ifc.frame_done), 32'd0);
      check({tag, "_busy_after"}, 32'(ifc.busy), 32'd0);
   endtask

   initial begin
      logic [15:0] px;
      bit          found;

      rst_n             = 1'b0;
      ifc.start         = 1'b0;
      ifc.n_cols        = 12'd0;
      ifc.n_rows        = 12'd0;
      ifc.ad_data       = 8'd0;
      ifc.ad_hi_valid   = 1'b0;
      ifc.ad_lo_valid   = 1'b0;
      ifc.tx_fifo_wfull = 1'b0;
      repeat (3) tick();
      check("rst_winc", 32'(ifc.tx_fifo_winc), 32'd0);
      check("rst_wdata", 32'(ifc.tx_fifo_wdata), 32'd0);
      check("rst_busy", 32'(ifc.busy), 32'd0);
      check("rst_done", 32'(ifc.frame_done), 32'd0);
      check("rst_ovf", 32'(ifc.overflow), 32'd0);
      rst_n = 1'b1;
      tick();

      // Basic 2x1 frame with latency measurement on the first pixel.
      start_frame("basic", 12'd2, 12'd1);
      wait_bytes("basic", 2);
      pix_q = '{16'h1234, 16'hABCD};
      ifc.ad_data = 8'h12; ifc.ad_hi_valid = 1'b1; tick();
      ifc.ad_hi_valid = 1'b0; tick();
      ifc.ad_data = 8'h34; ifc.ad_lo_valid = 1'b1; tick();
      ifc.ad_lo_valid = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (ifc.tx_fifo_winc) begin
            found = 1'b1;
            break;
         end
      end
      check("latency_winc", 32'(found), 32'd1);
      check("latency_byte", 32'(ifc.tx_fifo_wdata), 32'h12);
      send_px(16'hABCD, 2);
      wait_done("basic");
      build_exp(2, 8'h00);
      check_frame("basic");
      check("basic_ovf", 32'(ifc.overflow), 32'd0);

      // Empty frame: strobes produce nothing.
      start_frame("empty", 12'd0, 12'd5);
      for (int i = 0; i < 3; i++) send_px(16'($urandom), 1);
      wait_done("empty");
      pix_q.delete();
      build_exp(0, 8'h00);
      check_frame("empty");

      // Overflow with the fifo held full.
      start_frame("ovf", 12'd3, 12'd2);
      wait_bytes("ovf", 2);
      ifc.tx_fifo_wfull = 1'b1;
      pix_q.delete();
      for (int i = 0; i < 6; i++) begin
         px = 16'($urandom);
         pix_q.push_back(px);
         send_px(px, 1);
         repeat (2) tick();
      end
      ifc.tx_fifo_wfull = 1'b0;
      wait_done("ovf");
      build_exp(DEPTH, 8'(6 - DEPTH));
      check_frame("ovf");
      check("ovf_sticky", 32'(ifc.overflow), 32'd1);

      // Strobe corner cases: lo-only, simultaneous hi+lo, double hi.
      start_frame("strobe", 12'd1, 12'd1);
      wait_bytes("strobe", 2);
      ifc.ad_data = 8'h77; ifc.ad_lo_valid = 1'b1; tick();
      ifc.ad_lo_valid = 1'b0; tick();
      ifc.ad_data = 8'h99; ifc.ad_hi_valid = 1'b1; ifc.ad_lo_valid = 1'b1; tick();
      ifc.ad_hi_valid = 1'b0; ifc.ad_lo_valid = 1'b0; tick();
      ifc.ad_data = 8'h11; ifc.ad_hi_valid = 1'b1; tick();
      ifc.ad_hi_valid = 1'b0; tick();
      send_px(16'h2233, 1);
      wait_done("strobe");
      pix_q = '{16'h2233};
      build_exp(1, 8'h00);
      check_frame("strobe");

      // Long frame with random backpressure.
      rand_wfull = 1'b1;
      full_run   = 0;
      start_frame("rand", 12'd300, 12'd1);
      wait_bytes("rand", 2);
      pix_q.delete();
      for (int i = 0; i < 300; i++) begin
         px = 16'($urandom);
         pix_q.push_back(px);
         send_px(px, int'($urandom_range(1, 2)));
         repeat (8) tick();
      end
      wait_done("rand");
      rand_wfull = 1'b0;
      ifc.tx_fifo_wfull = 1'b0;
      build_exp(300, 8'h00);
      check_frame("rand");
      check("rand_ovf", 32'(ifc.overflow), 32'd0);
      check("rand_winc_while_full", 32'(viol_full), 32'd0);
      check("rand_back_to_back", 32'(viol_b2b), 32'd0);

      // Reset mid-frame, then a clean frame with an ignored second start.
      start_frame("abort", 12'd2, 12'd2);
      wait_bytes("abort", 2);
      send_px(16'hBEEF, 1);
      rst_n = 1'b0;
      tick();
      tick();
      check("abort_winc", 32'(ifc.tx_fifo_winc), 32'd0);
      check("abort_wdata", 32'(ifc.tx_fifo_wdata), 32'd0);
      check("abort_busy", 32'(ifc.busy), 32'd0);
      check("abort_done", 32'(ifc.frame_done), 32'd0);
      check("abort_ovf", 32'(ifc.overflow), 32'd0);
      rst_n = 1'b1;
      got.delete();
      repeat (10) tick();
      check("abort_no_trailer", 32'(got.size()), 32'd0);
      start_frame("clean", 12'd1, 12'd1);
      tick();
      tick();
      ifc.n_cols = 12'd5;
      ifc.n_rows = 12'd5;
      ifc.start  = 1'b1;
      tick();
      ifc.start  = 1'b0;
      wait_bytes("clean", 2);
      send_px(16'h0F0F, 1);
      wait_done("clean");
      pix_q = '{16'h0F0F};
      build_exp(1, 8'h00);
      check_frame("clean");
      repeat (20) tick();
      check("clean_no_extra", 32'(got.size()), 32'd7);
      check("all_winc_while_full", 32'(viol_full), 32'd0);
      check("all_back_to_back", 32'(viol_b2b), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
